rip_nr1w_bram_byte: RTL and testbench
=====================================

RIP_NR1W_BRAM_BYTE -- requirements
Module: rip_nr1w_bram_byte

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of B_WIDTH (8, from rip_const); elaboration error otherwise.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, giving depth 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports; must be 1..8.
REQ-004 SHALL have parameter RDW_MODE, default 0, read-during-write to same address: 0 = old data, 1 = new data (byte-merged).
REQ-005 SHALL have parameter OUT_REG, default 0, adding one output pipeline stage when 1.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1, zero-filling the array after reset when 1.
REQ-007 SHALL have port clk, input, 1 bit, the only clock; all logic on posedge.
REQ-008 SHALL have port rstn, input, 1 bit, reset that is asynchronous and active-low.
REQ-009 SHALL have port clear_req, input, 1 bit, single-cycle request to zero-fill the array.
REQ-010 SHALL have port busy, output, 1 bit, high while the clear sequence runs.
REQ-011 SHALL have port w_en, input, 1 bit, write port enable.
REQ-012 SHALL have port w_addr, input, ADDR_WIDTH bits, write address.
REQ-013 SHALL have port w_be, input, DATA_WIDTH/B_WIDTH bits, byte write enables; bit i covers bits [i*8 +: 8].
REQ-014 SHALL have port w_data, input, DATA_WIDTH bits, write data.
REQ-015 SHALL have port r_en, input, NUM_READ bits, per-port read enable.
REQ-016 SHALL have port r_addr, input, NUM_READ*ADDR_WIDTH bits, port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-017 SHALL have port r_data, output, NUM_READ*DATA_WIDTH bits, port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-018 SHALL have port r_valid, output, NUM_READ bits, one-cycle pulse marking r_data of port k valid.

Function
REQ-019 SHALL keep the array in block RAM; the array SHALL NOT be reset by rstn.
REQ-020 SHALL implement states CLEAR and READY; busy = (state == CLEAR), registered.
REQ-021 SHALL, on rstn deassertion, enter CLEAR when CLEAR_ON_RESET=1, else READY.
REQ-022 SHALL, in CLEAR, write all-zero to address clr_cnt each cycle, incrementing clr_cnt from 0; after address 2**ADDR_WIDTH-1 is written, the next state SHALL be READY (clear lasts exactly 2**ADDR_WIDTH cycles).
REQ-023 SHALL, on clear_req high in READY, enter CLEAR next cycle with clr_cnt=0; a write or read accepted in that same cycle SHALL complete normally.
REQ-024 SHALL, on clear_req high in CLEAR, restart clr_cnt at 0 next cycle.
REQ-025 SHALL accept a write only when w_en=1 and busy=0; only bytes with w_be[i]=1 are updated; w_en=1 with w_be=0 leaves memory unchanged.
REQ-026 SHALL accept a read on port k only when r_en[k]=1 and busy=0; ignored reads produce no r_valid.
REQ-027 SHALL assert r_valid[k] exactly 1+OUT_REG cycles after an accepted read, for one cycle per accepted read; back-to-back reads give back-to-back valids.
REQ-028 SHALL hold r_data of port k unchanged when no new read result is presented.
REQ-029 SHALL, when an accepted read and an accepted write address the same word in the same cycle, return the pre-write word if RDW_MODE=0, or per byte w_data where w_be set and old data elsewhere if RDW_MODE=1.
REQ-030 SHALL allow all read ports to access the same or different addresses simultaneously without stalls.

Reset
REQ-031 SHALL, while rstn=0, force r_data=0, r_valid=0, clr_cnt=0, pipeline registers 0, and busy=CLEAR_ON_RESET, immediately and independent of clk.
REQ-032 SHALL, when rstn is asserted mid-clear or mid-read, abandon the operation; no r_valid for reads in flight; clear restarts from 0 after deassertion.

Verification
REQ-033 Reset release with CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy high exactly 16 cycles; then read addr 0..15 -> all 0x00000000.
REQ-034 Write 0xDEADBEEF to addr 5 with w_be=4'b1111, then w_data=0x11223344, w_be=4'b0101 -> read addr 5 gives 0xDE22BE44.
REQ-035 RDW_MODE=1, addr 3 holds 0xAAAAAAAA; same cycle write 0x55555555 w_be=4'b0011 and read port 1 addr 3 -> r_data[1]=0xAAAA5555; with RDW_MODE=0 -> 0xAAAAAAAA.
REQ-036 OUT_REG=1, NUM_READ=3, three ports read addrs 1,2,1 in one cycle -> all r_valid bits pulse together exactly 2 cycles later with correct data.
REQ-037 clear_req at clr_cnt=7 during CLEAR -> busy extends to 16 cycles after the restart; reads and writes during busy produce no r_valid and no memory change.
REQ-038 rstn asserted mid-clear -> busy, r_valid and r_data immediately reset; after release, full 16-cycle clear repeats.

Source files
------------

// File: rtl/rip_nr1w_bram_byte.sv
// Block-RAM array with one byte-masked write port, NUM_READ independent read ports,
// optional output register and a hardware zero-fill sequence after reset or on request.
module rip_nr1w_bram_byte #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned NUM_READ       = 2,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear_req,
  output logic                           busy,
  input  logic                           w_en,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH/8-1:0]        w_be,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [NUM_READ-1:0]            r_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] r_data,
  output logic [NUM_READ-1:0]            r_valid
);

  localparam int unsigned B_WIDTH = 8;
  localparam int unsigned NB      = DATA_WIDTH / B_WIDTH;
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % B_WIDTH) != 0 || DATA_WIDTH == 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_num_read
    $error("NUM_READ must be in 1..8");
  end

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StReady = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? StClear : StReady;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
  logic                    w_busy;
  logic                    w_wr_acc;

  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [NB-1:0]           w_mem_be;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RST_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // A clear request always restarts the fill from address 0, even mid-clear.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    unique case (r_state)
      StClear: begin
        if (clear_req) begin
          w_clr_cnt_nxt = '0;
        end else if (&r_clr_cnt) begin
          w_state_nxt   = StReady;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      StReady: begin
        if (clear_req) begin
          w_state_nxt   = StClear;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = RST_STATE;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign w_busy   = (r_state == StClear);
  assign busy     = w_busy;
  assign w_wr_acc = w_en & ~w_busy;

  // The clear sequence owns the single write port while busy.
  assign w_mem_we    = w_busy | w_wr_acc;
  assign w_mem_addr  = w_busy ? r_clr_cnt : w_addr;
  assign w_mem_be    = w_busy ? '1 : w_be;
  assign w_mem_wdata = w_busy ? '0 : w_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_be[b]) begin
          r_mem[w_mem_addr][b*B_WIDTH +: B_WIDTH] <= w_mem_wdata[b*B_WIDTH +: B_WIDTH];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_vld;

    assign w_ra     = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rd_acc = r_en[k] & ~w_busy;

    // New-data mode forwards the written bytes over the stored word.
    always_comb begin
      w_rd_word = r_mem[w_ra];
      if (RDW_MODE != 0 && w_wr_acc && (w_addr == w_ra)) begin
        for (int b = 0; b < NB; b++) begin
          if (w_be[b]) begin
            w_rd_word[b*B_WIDTH +: B_WIDTH] = w_data[b*B_WIDTH +: B_WIDTH];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rd_vld  <= 1'b0;
        r_rd_data <= '0;
      end else begin
        r_rd_vld <= w_rd_acc;
        if (w_rd_acc) begin
          r_rd_data <= w_rd_word;
        end
      end
    end

    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_out_data;
      logic                  r_out_vld;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_out_vld  <= 1'b0;
          r_out_data <= '0;
        end else begin
          r_out_vld <= r_rd_vld;
          if (r_rd_vld) begin
            r_out_data <= r_rd_data;
          end
        end
      end

      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = r_out_data;
      assign r_valid[k]                         = r_out_vld;
    end else begin : g_no_out_reg
      assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = r_rd_data;
      assign r_valid[k]                         = r_rd_vld;
    end
  end

endmodule

// File: tb/tb_rip_nr1w_bram_byte.sv
// Two instances (new-data + output register, old-data + no register) share stimulus and are
// checked against a word-array model with a queue of pending read results per instance.
module tb_rip_nr1w_bram_byte;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NR    = 3;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn;
  logic               clear_req;
  logic               w_en;
  logic [AW-1:0]      w_addr;
  logic [NB-1:0]      w_be;
  logic [DW-1:0]      w_data;
  logic [NR-1:0]      r_en;
  logic [NR*AW-1:0]   r_addr;
  logic               busy_a, busy_b;
  logic [NR*DW-1:0]   r_data_a, r_data_b;
  logic [NR-1:0]      r_valid_a, r_valid_b;

  rip_nr1w_bram_byte #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .RDW_MODE(1), .OUT_REG(1),
    .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .rstn(rstn), .clear_req(clear_req), .busy(busy_a), .w_en(w_en),
    .w_addr(w_addr), .w_be(w_be), .w_data(w_data), .r_en(r_en), .r_addr(r_addr),
    .r_data(r_data_a), .r_valid(r_valid_a)
  );

  rip_nr1w_bram_byte #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .RDW_MODE(0), .OUT_REG(0),
    .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .rstn(rstn), .clear_req(clear_req), .busy(busy_b), .w_en(w_en),
    .w_addr(w_addr), .w_be(w_be), .w_data(w_data), .r_en(r_en), .r_addr(r_addr),
    .r_data(r_data_b), .r_valid(r_valid_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, remaining clear cycles, pending read results.
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mdl_mem [DEPTH];
  int          left;
  int          cyc;
  rd_t         qa[$];
  rd_t         qb[$];
  logic [NR-1:0] ev_a, ev_b;
  logic [31:0] ed_a [NR];
  logic [31:0] ed_b [NR];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ev_a = '0;
    ev_b = '0;
    for (int k = 0; k < NR; k++) begin
      ed_a[k] = '0;
      ed_b[k] = '0;
    end
    left = DEPTH;
  endtask

  task automatic model_edge();
    logic [3:0]  a;
    logic [31:0] old_w;
    rd_t         e;
    if (!rstn) return;
    cyc++;
    if (left == 0) begin
      for (int k = 0; k < NR; k++) begin
        if (r_en[k]) begin
          a     = r_addr[k*AW +: AW];
          old_w = mdl_mem[a];
          qb.push_back('{due: cyc, port: k, data: old_w});
          qa.push_back('{due: cyc + 1, port: k,
                         data: (w_en && w_addr == a) ? merge(old_w, w_data, w_be) : old_w});
        end
      end
      if (w_en) mdl_mem[w_addr] = merge(mdl_mem[w_addr], w_data, w_be);
    end
    if (clear_req) begin
      left = DEPTH;
    end else if (left > 0) begin
      left--;
      if (left == 0) for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    end
    ev_a = '0;
    ev_b = '0;
    while (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      ev_a[e.port] = 1'b1;
      ed_a[e.port] = e.data;
    end
    while (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      ev_b[e.port] = 1'b1;
      ed_b[e.port] = e.data;
    end
  endtask

  task automatic check_outputs();
    chk("busy_a", 32'(busy_a), 32'(left > 0));
    chk("busy_b", 32'(busy_b), 32'(left > 0));
    chk("valid_a", 32'(r_valid_a), 32'(ev_a));
    chk("valid_b", 32'(r_valid_b), 32'(ev_b));
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("data_a%0d", k), r_data_a[k*DW +: DW], ed_a[k]);
      chk($sformatf("data_b%0d", k), r_data_b[k*DW +: DW], ed_b[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    clear_req = 1'b0;
    w_en      = 1'b0;
    w_addr    = '0;
    w_be      = '0;
    w_data    = '0;
    r_en      = '0;
    r_addr    = '0;
  endtask

  // Outputs must collapse as soon as rstn falls, without any clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) cycle();
    rstn = 1'b1;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (busy_b && n < 100) begin
      cycle();
      n++;
    end
    idle();
    chk(name, 32'(n), 32'd16);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      r_en   = 3'b001 << (a % NR);
      r_addr = 12'(a) << (AW * (a % NR));
      cycle();
    end
    idle();
    repeat (2) cycle();
  endtask

  typedef struct packed {
    logic            we;
    logic [3:0]      wa;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [2:0]      ren;
    logic [2:0][3:0] ra;
    logic [2:0][31:0] ea;
    logic [2:0][31:0] eb;
  } vec_t;

  vec_t vt [12];

  initial begin
    int n;
    vt[0]  = '{1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 3'b000, 12'h0, 96'h0, 96'h0};
    vt[1]  = '{1'b1, 4'd5, 4'h5, 32'h11223344, 3'b000, 12'h0, 96'h0, 96'h0};
    vt[2]  = '{1'b0, 4'd0, 4'h0, 32'h0, 3'b001, {4'd0, 4'd0, 4'd5},
               {32'h0, 32'h0, 32'hDE22BE44}, {32'h0, 32'h0, 32'hDE22BE44}};
    vt[3]  = '{1'b1, 4'd3, 4'hF, 32'hAAAAAAAA, 3'b000, 12'h0, 96'h0, 96'h0};
    vt[4]  = '{1'b1, 4'd3, 4'h3, 32'h55555555, 3'b010, {4'd0, 4'd3, 4'd0},
               {32'h0, 32'hAAAA5555, 32'h0}, {32'h0, 32'hAAAAAAAA, 32'h0}};
    vt[5]  = '{1'b0, 4'd0, 4'h0, 32'h0, 3'b001, {4'd0, 4'd0, 4'd3},
               {32'h0, 32'h0, 32'hAAAA5555}, {32'h0, 32'h0, 32'hAAAA5555}};
    vt[6]  = '{1'b1, 4'd1, 4'hF, 32'h01010101, 3'b000, 12'h0, 96'h0, 96'h0};
    vt[7]  = '{1'b1, 4'd2, 4'hF, 32'h02020202, 3'b000, 12'h0, 96'h0, 96'h0};
    vt[8]  = '{1'b0, 4'd0, 4'h0, 32'h0, 3'b111, {4'd1, 4'd2, 4'd1},
               {32'h01010101, 32'h02020202, 32'h01010101},
               {32'h01010101, 32'h02020202, 32'h01010101}};
    vt[9]  = '{1'b1, 4'd2, 4'h0, 32'hFFFFFFFF, 3'b100, {4'd2, 4'd0, 4'd0},
               {32'h02020202, 32'h0, 32'h0}, {32'h02020202, 32'h0, 32'h0}};
    vt[10] = '{1'b1, 4'd5, 4'h8, 32'h77000000, 3'b111, {4'd2, 4'd3, 4'd5},
               {32'h02020202, 32'hAAAA5555, 32'h7722BE44},
               {32'h02020202, 32'hAAAA5555, 32'hDE22BE44}};
    vt[11] = '{1'b0, 4'd0, 4'h0, 32'h0, 3'b001, {4'd0, 4'd0, 4'd5},
               {32'h0, 32'h0, 32'h7722BE44}, {32'h0, 32'h0, 32'h7722BE44}};

    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    cyc = 0;
    idle();
    rstn = 1'b1;
    #2;
    do_reset();
    wait_clear("busy_len_after_reset");
    read_all();

    // Directed vectors: results checked at latency 1 (old-data) and 2 (new-data, registered).
    for (int i = 0; i < 12; i++) begin
      w_en   = vt[i].we;
      w_addr = vt[i].wa;
      w_be   = vt[i].be;
      w_data = vt[i].wd;
      r_en   = vt[i].ren;
      r_addr = vt[i].ra;
      cycle();
      idle();
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("tbl%0d_vld_b%0d", i, k), 32'(r_valid_b[k]), 32'(vt[i].ren[k]));
        if (vt[i].ren[k]) chk($sformatf("tbl%0d_dat_b%0d", i, k), r_data_b[k*DW +: DW], vt[i].eb[k]);
      end
      cycle();
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("tbl%0d_vld_a%0d", i, k), 32'(r_valid_a[k]), 32'(vt[i].ren[k]));
        if (vt[i].ren[k]) chk($sformatf("tbl%0d_dat_a%0d", i, k), r_data_a[k*DW +: DW], vt[i].ea[k]);
      end
    end

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 500; i++) begin
      w_en      = 1'($urandom_range(0, 1));
      w_addr    = 4'($urandom_range(0, 15));
      w_be      = 4'($urandom);
      w_data    = $urandom;
      r_en      = 3'($urandom);
      r_addr    = 12'($urandom);
      clear_req = ($urandom_range(0, 79) == 0);
      cycle();
    end
    idle();
    n = 0;
    while (busy_b && n < 40) begin
      cycle();
      n++;
    end
    repeat (2) cycle();

    // Restart a clear at count 7 while hammering the ports.
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (7) cycle();
    clear_req = 1'b1;
    w_en      = 1'b1;
    w_addr    = 4'd0;
    w_be      = 4'hF;
    w_data    = 32'hFFFFFFFF;
    r_en      = 3'b111;
    cycle();
    clear_req = 1'b0;
    wait_clear("busy_len_after_restart");
    read_all();

    // Reset with reads in flight.
    w_en   = 1'b1;
    w_addr = 4'd9;
    w_be   = 4'hF;
    w_data = 32'hCAFEF00D;
    cycle();
    idle();
    r_en   = 3'b111;
    r_addr = {4'd9, 4'd9, 4'd9};
    cycle();
    idle();
    do_reset();
    wait_clear("busy_len_after_inflight_reset");

    // Reset in the middle of a clear.
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (5) cycle();
    do_reset();
    wait_clear("busy_len_after_midclear_reset");
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
